// File: rtl/gpio_in_debounce.sv
// Synchronises async GPIO pad inputs and debounces each bit with a programmable stability window.
// Latency: SYNC_STAGES + max(debounce_cycles_i,1) - 1 edges from first sample to gpio_db_o/pulses.
// No backpressure: level and pulse outputs only, all registered.
module gpio_in_debounce #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter int               CNT_WIDTH   = 16,
    parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [WIDTH-1:0]     gpio_raw_i,
    input  logic [CNT_WIDTH-1:0] debounce_cycles_i,
    output logic [WIDTH-1:0]     gpio_db_o,
    output logic [WIDTH-1:0]     rise_o,
    output logic [WIDTH-1:0]     fall_o,
    output logic                 change_o
);

    logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     stable_q;
    logic [WIDTH-1:0]     stable_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_lim;
    logic [WIDTH-1:0]     pending;
    logic [WIDTH-1:0]     commit;
    logic [WIDTH-1:0]     rise_q;
    logic [WIDTH-1:0]     rise_d;
    logic [WIDTH-1:0]     fall_q;
    logic [WIDTH-1:0]     fall_d;
    logic                 change_q;
    logic                 change_d;

    assign s = sync_q[SYNC_STAGES-1];

    // A window of 0 behaves as 1, so the commit threshold saturates at zero.
    assign cnt_lim = (debounce_cycles_i == '0) ? '0 : debounce_cycles_i - CNT_WIDTH'(1);

    // Per-bit state decode: PENDING while the synchronised input differs from the debounced state.
    always_comb begin
        pending = s ^ stable_q;
        commit  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            commit[i] = pending[i] && (cnt_q[i] >= cnt_lim);
        end
    end

    always_comb begin
        stable_d = stable_q ^ commit;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (pending[i] && !commit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        rise_d   = commit & s;
        fall_d   = commit & ~s;
        change_d = |commit;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RESET_VAL;
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= RESET_VAL;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            sync_q[0] <= gpio_raw_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign gpio_db_o = stable_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign change_o  = change_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce: reset, clean edges, glitch rejection, window edge cases, multi-bit.
module tb_gpio_in_debounce;

    logic        clk;
    logic        rstn;
    logic [7:0]  gpio_raw_i;
    logic [15:0] debounce_cycles_i;
    logic [7:0]  gpio_db_o;
    logic [7:0]  rise_o;
    logic [7:0]  fall_o;
    logic        change_o;

    int checks   = 0;
    int failures = 0;

    gpio_in_debounce #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .CNT_WIDTH   (16),
        .RESET_VAL   (8'h00)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .gpio_raw_i        (gpio_raw_i),
        .debounce_cycles_i (debounce_cycles_i),
        .gpio_db_o         (gpio_db_o),
        .rise_o            (rise_o),
        .fall_o            (fall_o),
        .change_o          (change_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges; outputs are observed 1 time unit after the last edge.
    task automatic step(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {7'd0, gpio_db_o, rise_o, fall_o, change_o};
    endfunction

    initial begin
        logic bad;

        // Reset held for 3 edges with all pads high.
        rstn              = 1'b0;
        gpio_raw_i        = 8'hFF;
        debounce_cycles_i = 16'd4;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check("reset_hold", all_out(), 32'h0);
        end

        // Release: first sample at E, commit at E+5.
        rstn = 1'b1;
        step(5);
        check("rel_db_before", {24'd0, gpio_db_o}, 32'h00);
        check("rel_rise_before", {24'd0, rise_o}, 32'h00);
        step(1);
        check("rel_rise", {24'd0, rise_o}, 32'hFF);
        check("rel_db", {24'd0, gpio_db_o}, 32'hFF);
        check("rel_change", {31'd0, change_o}, 32'h1);
        step(1);
        check("rel_rise_width", {24'd0, rise_o}, 32'h00);
        check("rel_change_width", {31'd0, change_o}, 32'h0);

        // All pads low again.
        gpio_raw_i = 8'h00;
        step(6);
        check("all_fall", {24'd0, fall_o}, 32'hFF);
        check("all_fall_db", {24'd0, gpio_db_o}, 32'h00);
        step(1);

        // Clean rising edge on bit0.
        gpio_raw_i = 8'h01;
        step(5);
        check("clean_db_before", {24'd0, gpio_db_o}, 32'h00);
        step(1);
        check("clean_rise_all", all_out(), {7'd0, 8'h01, 8'h01, 8'h00, 1'b1});
        step(1);
        check("clean_rise_gone", all_out(), {7'd0, 8'h01, 8'h00, 8'h00, 1'b0});

        // Clean falling edge on bit0.
        gpio_raw_i = 8'h00;
        step(5);
        check("clean_fall_before", {24'd0, fall_o}, 32'h00);
        step(1);
        check("clean_fall_all", all_out(), {7'd0, 8'h00, 8'h00, 8'h01, 1'b1});
        step(1);

        // Glitch: bit3 high for 3 samples only, must never reach the outputs.
        bad = 1'b0;
        gpio_raw_i = 8'h08;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) gpio_raw_i = 8'h00;
            step(1);
            if (all_out() != 32'h0) bad = 1'b1;
        end
        check("glitch_reject", {31'd0, bad}, 32'h0);

        // Bounce 1,0 then steady 1: rise 5 edges after the first steady sample.
        gpio_raw_i = 8'h01;
        step(1);
        gpio_raw_i = 8'h00;
        step(1);
        gpio_raw_i = 8'h01;
        step(5);
        check("bounce_db_before", {24'd0, gpio_db_o}, 32'h00);
        step(1);
        check("bounce_rise", {24'd0, rise_o}, 32'h01);
        step(1);

        // N=0 behaves as N=1: latency of 2 edges.
        debounce_cycles_i = 16'd0;
        gpio_raw_i = 8'h00;
        step(2);
        check("n0_db_before", {24'd0, gpio_db_o}, 32'h01);
        step(1);
        check("n0_fall", {16'd0, gpio_db_o, fall_o}, {16'd0, 8'h00, 8'h01});

        debounce_cycles_i = 16'd1;
        gpio_raw_i = 8'h01;
        step(2);
        check("n1_db_before", {24'd0, gpio_db_o}, 32'h00);
        step(1);
        check("n1_rise", {16'd0, gpio_db_o, rise_o}, {16'd0, 8'h01, 8'h01});
        gpio_raw_i = 8'h00;
        step(3);
        check("n1_back_low", {24'd0, gpio_db_o}, 32'h00);

        // Window lowered mid-count: 10 PENDING cycles at N=100, then N=4 commits next edge.
        debounce_cycles_i = 16'd100;
        gpio_raw_i = 8'h20;
        step(12);
        check("win_db_before", {24'd0, gpio_db_o}, 32'h00);
        debounce_cycles_i = 16'd4;
        step(1);
        check("win_commit", {16'd0, gpio_db_o, rise_o}, {16'd0, 8'h20, 8'h20});
        gpio_raw_i = 8'h00;
        step(7);
        check("win_back_low", {24'd0, gpio_db_o}, 32'h00);

        // Maximum window: commit exactly at E+65536, nothing earlier.
        debounce_cycles_i = 16'hFFFF;
        gpio_raw_i = 8'h40;
        bad = 1'b0;
        for (int c = 0; c < 65536; c++) begin
            step(1);
            if (gpio_db_o != 8'h00 || change_o) bad = 1'b1;
        end
        check("maxwin_no_early", {31'd0, bad}, 32'h0);
        step(1);
        check("maxwin_commit", {16'd0, gpio_db_o, rise_o}, {16'd0, 8'h40, 8'h40});
        debounce_cycles_i = 16'd1;
        gpio_raw_i = 8'h00;
        step(4);
        check("maxwin_back_low", {24'd0, gpio_db_o}, 32'h00);

        // Multi-bit simultaneous rise.
        debounce_cycles_i = 16'd4;
        gpio_raw_i = 8'hA5;
        step(5);
        check("multi_db_before", {24'd0, gpio_db_o}, 32'h00);
        step(1);
        check("multi_rise", all_out(), {7'd0, 8'hA5, 8'hA5, 8'h00, 1'b1});
        step(1);
        check("multi_rise_gone", {24'd0, rise_o}, 32'h00);

        // Reset during PENDING: state back to RESET_VAL, count restarts after release.
        gpio_raw_i = 8'h5A;
        step(4);
        check("midrst_pending", {24'd0, gpio_db_o}, 32'hA5);
        rstn = 1'b0;
        step(1);
        check("midrst_reset", all_out(), 32'h0);
        rstn = 1'b1;
        step(5);
        check("midrst_restart_before", {16'd0, gpio_db_o, rise_o}, 32'h0);
        step(1);
        check("midrst_rise", all_out(), {7'd0, 8'h5A, 8'h5A, 8'h00, 1'b1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
